// File: rtl/k_rctl_t3.sv
// Read-side control for a dual-clock FIFO: it synchronizes the Gray write pointer into the
// read domain and keeps the binary and Gray read pointers. It also registers the empty flag,
// the almost-empty flag and a pessimistic fill-level estimate.
module k_rctl_t3 #(
    parameter int unsigned addr_size = 4,
    parameter int unsigned ae_level  = 2
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [addr_size:0]   wptr,
    input  logic                 rinc,
    output logic [addr_size-1:0] raddr,
    output logic [addr_size:0]   rptr,
    output logic                 rempty,
    output logic                 ralmost_empty,
    output logic [addr_size:0]   rcount
);

    localparam int unsigned Aw = addr_size + 1;
    localparam logic [addr_size:0] AeLevel = Aw'(ae_level);

    logic [addr_size:0] rq1_wptr_q, rq1_wptr_d;
    logic [addr_size:0] rq2_wptr_q, rq2_wptr_d;
    logic [addr_size:0] rbin_q, rbin_d;
    logic [addr_size:0] rptr_q, rptr_d;
    logic               rempty_q, rempty_d;
    logic               ralmost_empty_q, ralmost_empty_d;
    logic [addr_size:0] rcount_q, rcount_d;

    logic               rget;
    logic [addr_size:0] rbinnext;
    logic [addr_size:0] rgraynext;
    logic [addr_size:0] wbin_s;
    logic [addr_size:0] fill;

    // Pointer advance, write-pointer decode and registered flag/level computation.
    always_comb begin
        // A request while empty is dropped silently.
        rget      = rinc & ~rempty_q;
        rbinnext  = rbin_q + Aw'(rget);
        rgraynext = (rbinnext >> 1) ^ rbinnext;

        // Gray to binary: each bit is the XOR of itself and all bits above it.
        wbin_s = '0;
        for (int i = 0; i <= int'(addr_size); i++) begin
            wbin_s[i] = ^(rq2_wptr_q >> i);
        end

        // Uses the post-read pointer so reads are reflected at once and writes lag.
        fill = wbin_s - rbinnext;

        rq1_wptr_d      = wptr;
        rq2_wptr_d      = rq1_wptr_q;
        rbin_d          = rbinnext;
        rptr_d          = rgraynext;
        // Full-width compare: the MSB wrap bit separates empty from full.
        rempty_d        = (rgraynext == rq2_wptr_q);
        ralmost_empty_d = (fill <= AeLevel);
        rcount_d        = fill;
    end

    // State registers with synchronous active-high reset; reset wins over rinc.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rq1_wptr_q      <= '0;
            rq2_wptr_q      <= '0;
            rbin_q          <= '0;
            rptr_q          <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rcount_q        <= '0;
        end else begin
            rq1_wptr_q      <= rq1_wptr_d;
            rq2_wptr_q      <= rq2_wptr_d;
            rbin_q          <= rbin_d;
            rptr_q          <= rptr_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rcount_q        <= rcount_d;
        end
    end

    assign raddr         = rbin_q[addr_size-1:0];
    assign rptr          = rptr_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rcount        = rcount_q;

endmodule

// File: tb/tb_k_rctl_t3.sv
// Self-checking bench for k_rctl_t3: a word-count reference model plus directed checkpoints.
module tb_k_rctl_t3;

    localparam int AddrSize = 4;
    localparam int AeLevel  = 2;
    localparam int Depth    = 16;
    localparam int Mod      = 32;

    logic                rclk = 1'b0;
    logic                rrst;
    logic [AddrSize:0]   wptr;
    logic                rinc;
    logic [AddrSize-1:0] raddr;
    logic [AddrSize:0]   rptr;
    logic                rempty;
    logic                ralmost_empty;
    logic [AddrSize:0]   rcount;

    k_rctl_t3 #(
        .addr_size(AddrSize),
        .ae_level (AeLevel)
    ) dut (
        .rclk         (rclk),
        .rrst         (rrst),
        .wptr         (wptr),
        .rinc         (rinc),
        .raddr        (raddr),
        .rptr         (rptr),
        .rempty       (rempty),
        .ralmost_empty(ralmost_empty),
        .rcount       (rcount)
    );

    always #5 rclk = ~rclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: counts of words written/read, and the write count
    // as seen after the two-stage crossing.
    int wr_total = 0;
    int m_rd     = 0;
    int m_q1     = 0;
    int m_q2     = 0;
    int m_cnt    = 0;
    bit m_empty  = 1'b1;
    bit m_ae     = 1'b1;
    bit checking = 1'b0;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) % Mod;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_wr(input int n);
        wr_total = ((n % Mod) + Mod) % Mod;
        wptr     = (AddrSize + 1)'(gray(wr_total));
    endtask

    task automatic model_edge();
        if (rrst) begin
            m_q1 = 0; m_q2 = 0; m_rd = 0; m_cnt = 0;
            m_empty = 1'b1; m_ae = 1'b1;
        end else begin
            if (rinc && !m_empty) m_rd = (m_rd + 1) % Mod;
            m_cnt   = (m_q2 - m_rd + Mod) % Mod;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= AeLevel);
            m_q2    = m_q1;
            m_q1    = wr_total;
        end
    endtask

    task automatic step();
        @(posedge rclk);
        model_edge();
        #1;
        if (checking) begin
            check_eq("raddr", 32'(raddr), 32'(m_rd % Depth));
            check_eq("rptr", 32'(rptr), 32'(gray(m_rd)));
            check_eq("rempty", 32'(rempty), 32'(m_empty));
            check_eq("ralmost_empty", 32'(ralmost_empty), 32'(m_ae));
            check_eq("rcount", 32'(rcount), 32'(m_cnt));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rrst = 1'b1;
        rinc = 1'b0;
        checking = 1'b1;
        // Reset with two words already written on the other side.
        set_wr(2);
        idle(2);
        check_eq("rst_rcount", 32'(rcount), 32'd0);
        check_eq("rst_rempty", 32'(rempty), 32'd1);
        rrst = 1'b0;
        idle(2);
        check_eq("rel_still_empty", 32'(rempty), 32'd1);
        step();
        check_eq("rel_rcount", 32'(rcount), 32'd2);
        check_eq("rel_rempty", 32'(rempty), 32'd0);

        // Drain three words with a five-cycle read burst.
        set_wr(3);
        idle(4);
        rinc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("drain_raddr", 32'(raddr), 32'((i < 3) ? i + 1 : 3));
        end
        rinc = 1'b0;
        check_eq("drain_rptr", 32'(rptr), 32'b00010);
        check_eq("drain_empty", 32'(rempty), 32'd1);

        // Single-word crossing latency.
        set_wr(4);
        idle(2);
        check_eq("sync_hold", 32'(rempty), 32'd1);
        step();
        check_eq("sync_empty", 32'(rempty), 32'd0);
        check_eq("sync_rcount", 32'(rcount), 32'd1);
        check_eq("sync_ae", 32'(ralmost_empty), 32'd1);
        rinc = 1'b1;
        step();
        rinc = 1'b0;

        // Full depth, then read everything.
        set_wr(m_rd + Depth);
        idle(4);
        check_eq("full_rcount", 32'(rcount), 32'd16);
        check_eq("full_ae", 32'(ralmost_empty), 32'd0);
        rinc = 1'b1;
        idle(Depth + 4);
        rinc = 1'b0;
        check_eq("full_drained", 32'(rempty), 32'd1);
        check_eq("full_rptr", 32'(rptr), 32'(gray(wr_total)));

        // Random traffic; pointers wrap many times. Writes never exceed depth.
        for (int blk = 0; blk < 8; blk++) begin
            int wr_rate = $urandom_range(10, 90);
            int rd_rate = $urandom_range(10, 90);
            for (int i = 0; i < 100; i++) begin
                if (((wr_total - m_rd + Mod) % Mod) < Depth && $urandom_range(0, 99) < wr_rate)
                    set_wr(wr_total + 1);
                rinc = ($urandom_range(0, 99) < rd_rate);
                step();
            end
        end

        // Reset in the middle of a drain with a read requested at the same edge.
        rinc = 1'b1;
        idle(25);
        rinc = 1'b0;
        set_wr(wr_total + 5);
        idle(4);
        check_eq("mid_rcount", 32'(rcount), 32'd5);
        rrst = 1'b1;
        rinc = 1'b1;
        set_wr(0);
        step();
        check_eq("mid_rst_raddr", 32'(raddr), 32'd0);
        check_eq("mid_rst_rcount", 32'(rcount), 32'd0);
        check_eq("mid_rst_empty", 32'(rempty), 32'd1);
        rrst = 1'b0;
        rinc = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
